wb_arbiter: RTL and testbench

Write-back arbiter between the execute units (ALU, MDU, ...) and the reorder-buffer write-back port. It collects registered results from `NPORT` execute-unit write-back masters and grants one per cycle. The granted result is held in a single output register and presented to the ROB. Stall and flush are propagated so that no result is lost or duplicated.

---
 rtl/wb_arbiter.sv | 84 ++++++++
 tb/tb_wb_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter from NPORT execute-unit result ports into one registered ROB write-back slot.
//   Config macro WB_ARB_ROUNDROBIN_EN: defined -> round-robin from a rotating pointer; undefined -> fixed priority (lowest index wins).
//   Ports: clk_i, arstn_i (async active-low), flush_i;
//          in_valid_i/in_ready_o [NPORT], in_data_i/in_csrdata_i [NPORT*XLEN], in_itag_i [NPORT*ITAG_W];
//          rob_valid_o/rob_ready_i, rob_data_o/rob_csrdata_o [XLEN], rob_itag_o [ITAG_W], rob_src_o [SRC_W].
module wb_arbiter #(
  parameter int NPORT  = 2,
  parameter int XLEN   = 64,
  parameter int ITAG_W = 8,
  parameter int SRC_W  = $clog2(NPORT)
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    flush_i,
  input  logic [NPORT-1:0]        in_valid_i,
  output logic [NPORT-1:0]        in_ready_o,
  input  logic [NPORT*XLEN-1:0]   in_data_i,
  input  logic [NPORT*XLEN-1:0]   in_csrdata_i,
  input  logic [NPORT*ITAG_W-1:0] in_itag_i,
  output logic                    rob_valid_o,
  input  logic                    rob_ready_i,
  output logic [XLEN-1:0]         rob_data_o,
  output logic [XLEN-1:0]         rob_csrdata_o,
  output logic [ITAG_W-1:0]       rob_itag_o,
  output logic [SRC_W-1:0]        rob_src_o
);
  logic              r_valid;
  logic [XLEN-1:0]   r_data, r_csrdata;
  logic [ITAG_W-1:0] r_itag;
  logic [SRC_W-1:0]  r_src;
  logic              w_take, w_any;
  logic [SRC_W-1:0]  w_base, w_sel;
  logic [SRC_W:0]    w_k;
  // Transfers are also blocked while reset is held so no port sees a handshake that the reset then discards.
  assign w_take     = (!r_valid | rob_ready_i) & !flush_i & arstn_i;
  assign in_ready_o = (w_any & w_take) ? (NPORT'(1) << w_sel) : '0;
`ifdef WB_ARB_ROUNDROBIN_EN
  logic [SRC_W-1:0] r_ptr;
  // Explicit wrap so non-power-of-two NPORT returns to port 0.
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) r_ptr <= '0;
    else if (w_any & w_take) r_ptr <= (w_sel == SRC_W'(NPORT-1)) ? '0 : w_sel + 1'b1;
  assign w_base = r_ptr;
`else
  assign w_base = '0;
`endif
  // Scan from farthest to nearest relative to w_base; the last hit is the closest valid port.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    w_k   = '0;
    for (int i = NPORT-1; i >= 0; i--) begin
      w_k = {1'b0, w_base} + (SRC_W+1)'(i);
      w_k = (w_k >= (SRC_W+1)'(NPORT)) ? w_k - (SRC_W+1)'(NPORT) : w_k;
      if (in_valid_i[w_k[SRC_W-1:0]]) begin
        w_sel = w_k[SRC_W-1:0];
        w_any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_csrdata <= '0;
      r_itag    <= '0;
      r_src     <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_take) begin
      r_valid <= w_any;
      if (w_any) begin
        r_data    <= in_data_i[w_sel*XLEN +: XLEN];
        r_csrdata <= in_csrdata_i[w_sel*XLEN +: XLEN];
        r_itag    <= in_itag_i[w_sel*ITAG_W +: ITAG_W];
        r_src     <= w_sel;
      end
    end
  assign rob_valid_o   = r_valid;
  assign rob_data_o    = r_data;
  assign rob_csrdata_o = r_csrdata;
  assign rob_itag_o    = r_itag;
  assign rob_src_o     = r_src;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector bench for wb_arbiter (NPORT=2 table plus NPORT=3 wrap sequence).
module tb_wb_arbiter;
`ifdef WB_ARB_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [63:0] K  = 64'h0000_0000_0000_ffff;
  localparam logic [63:0] A  = 64'h100;
  localparam logic [63:0] B  = 64'h200;
  localparam logic [63:0] DB = 64'hdead_beef;
  localparam logic [63:0] P  = 64'h5555;
  localparam logic [63:0] Q  = 64'h33;
  localparam logic [63:0] W  = 64'h44;
  typedef struct {
    logic [1:0]  v;
    logic        rr, fl;
    logic [7:0]  t0, t1;
    logic [63:0] d0, d1;
    logic [1:0]  rdy;
    logic        ov;
    logic [7:0]  tag;
    logic        src;
    logic [63:0] dat;
  } vec_t;
  logic         clk = 1'b0;
  logic         arstn, flush, rr;
  logic [1:0]   v2, rdy2;
  logic [127:0] d2, c2;
  logic [15:0]  t2;
  logic         ov2, os2;
  logic [63:0]  od2, oc2;
  logic [7:0]   ot2;
  logic [2:0]   v3, rdy3;
  logic [191:0] d3, c3;
  logic [23:0]  t3;
  logic         ov3;
  logic [63:0]  od3, oc3;
  logic [7:0]   ot3;
  logic [1:0]   os3;
  int           n_vec = 0;
  int           n_err = 0;
  vec_t         tv[15];
  always #5 clk = ~clk;
  wb_arbiter #(.NPORT(2), .XLEN(64), .ITAG_W(8)) u2 (
    .clk_i(clk), .arstn_i(arstn), .flush_i(flush),
    .in_valid_i(v2), .in_ready_o(rdy2), .in_data_i(d2), .in_csrdata_i(c2), .in_itag_i(t2),
    .rob_valid_o(ov2), .rob_ready_i(rr), .rob_data_o(od2), .rob_csrdata_o(oc2),
    .rob_itag_o(ot2), .rob_src_o(os2)
  );
  wb_arbiter #(.NPORT(3), .XLEN(64), .ITAG_W(8)) u3 (
    .clk_i(clk), .arstn_i(arstn), .flush_i(flush),
    .in_valid_i(v3), .in_ready_o(rdy3), .in_data_i(d3), .in_csrdata_i(c3), .in_itag_i(t3),
    .rob_valid_o(ov3), .rob_ready_i(rr), .rob_data_o(od3), .rob_csrdata_o(oc3),
    .rob_itag_o(ot3), .rob_src_o(os3)
  );
  function automatic vec_t mk(input logic [1:0] v, input logic r, input logic f,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [63:0] x, input logic [63:0] y,
                              input logic [1:0] rd, input logic o, input logic [7:0] tg,
                              input logic s, input logic [63:0] dt);
    mk = '{v, r, f, a, b, x, y, rd, o, tg, s, dt};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t x, input int i);
    v2    = x.v;
    rr    = x.rr;
    flush = x.fl;
    t2    = {x.t1, x.t0};
    d2    = {x.d1, x.d0};
    c2    = {x.d1 ^ K, x.d0 ^ K};
    #1;
    chk($sformatf("v%0d in_ready", i), 64'(rdy2), 64'(x.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d rob_valid", i), 64'(ov2), 64'(x.ov));
    if (x.ov) begin
      chk($sformatf("v%0d rob_itag", i), 64'(ot2), 64'(x.tag));
      chk($sformatf("v%0d rob_src", i), 64'(os2), 64'(x.src));
      chk($sformatf("v%0d rob_data", i), od2, x.dat);
      chk($sformatf("v%0d rob_csrdata", i), oc2, x.dat ^ K);
    end
  endtask
  task automatic step3(input string n, input logic [2:0] v, input logic [2:0] er, input logic [1:0] es);
    v3 = v;
    rr = 1'b1;
    #1;
    chk({n, " in_ready"}, 64'(rdy3), 64'(er));
    @(posedge clk);
    #1;
    chk({n, " rob_valid"}, 64'(ov3), 64'(1'b1));
    chk({n, " rob_src"}, 64'(os3), 64'(es));
    chk({n, " rob_itag"}, 64'(ot3), 64'(8'h30 + 8'(es)));
  endtask
  initial begin
    tv[0]  = mk(2'b11, 1'b1, 1'b0, 8'h10, 8'h20, A, B, 2'b01, 1'b1, 8'h10, 1'b0, A);
    tv[1]  = mk(2'b11, 1'b1, 1'b0, 8'h10, 8'h20, A, B, RR ? 2'b10 : 2'b01, 1'b1, RR ? 8'h20 : 8'h10, RR, RR ? B : A);
    tv[2]  = mk(2'b11, 1'b1, 1'b0, 8'h10, 8'h20, A, B, 2'b01, 1'b1, 8'h10, 1'b0, A);
    tv[3]  = tv[1];
    tv[4]  = mk(2'b10, 1'b1, 1'b0, 8'h10, 8'h21, A, DB, 2'b10, 1'b1, 8'h21, 1'b1, DB);
    tv[5]  = mk(2'b01, 1'b0, 1'b0, 8'h11, 8'h21, P, DB, 2'b00, 1'b1, 8'h21, 1'b1, DB);
    tv[6]  = tv[5];
    tv[7]  = tv[5];
    tv[8]  = mk(2'b01, 1'b1, 1'b0, 8'h11, 8'h21, P, DB, 2'b01, 1'b1, 8'h11, 1'b0, P);
    tv[9]  = mk(2'b01, 1'b1, 1'b0, 8'h33, 8'h21, Q, DB, 2'b01, 1'b1, 8'h33, 1'b0, Q);
    tv[10] = mk(2'b01, 1'b1, 1'b1, 8'h44, 8'h21, W, DB, 2'b00, 1'b0, 8'h00, 1'b0, W);
    tv[11] = mk(2'b01, 1'b1, 1'b0, 8'h44, 8'h21, W, DB, 2'b01, 1'b1, 8'h44, 1'b0, W);
    tv[12] = mk(2'b00, 1'b1, 1'b0, 8'h44, 8'h21, W, DB, 2'b00, 1'b0, 8'h00, 1'b0, W);
    tv[13] = mk(2'b11, 1'b1, 1'b0, 8'h10, 8'h20, A, B, RR ? 2'b10 : 2'b01, 1'b1, RR ? 8'h20 : 8'h10, RR, RR ? B : A);
    tv[14] = mk(2'b11, 1'b0, 1'b0, 8'h10, 8'h20, A, B, 2'b00, 1'b1, RR ? 8'h20 : 8'h10, RR, RR ? B : A);
    arstn = 1'b0;
    flush = 1'b0;
    rr    = 1'b1;
    v2    = 2'b11;
    d2    = {B, A};
    c2    = {B ^ K, A ^ K};
    t2    = 16'h2010;
    v3    = 3'b111;
    d3    = {64'h3, 64'h2, 64'h1};
    c3    = {64'h13, 64'h12, 64'h11};
    t3    = 24'h323130;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rob_valid", 64'(ov2), 64'(1'b0));
    chk("reset rob_data", od2, 64'h0);
    chk("reset rob_csrdata", oc2, 64'h0);
    chk("reset rob_itag", 64'(ot2), 64'h0);
    chk("reset rob_src", 64'(os2), 64'h0);
    chk("reset in_ready", 64'(rdy2), 64'h0);
    chk("reset3 rob_valid", 64'(ov3), 64'h0);
    chk("reset3 in_ready", 64'(rdy3), 64'h0);
    arstn = 1'b1;
    v3    = 3'b000;
    for (int i = 0; i < 15; i++) run(tv[i], i);
    arstn = 1'b0;
    #1;
    chk("async reset rob_valid", 64'(ov2), 64'h0);
    chk("async reset rob_data", od2, 64'h0);
    chk("async reset rob_itag", 64'(ot2), 64'h0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    v2    = 2'b00;
    step3("wrap p2", 3'b100, 3'b100, 2'd2);
    step3("wrap p0", 3'b011, 3'b001, 2'd0);
    step3("after wrap", 3'b011, RR ? 3'b010 : 3'b001, RR ? 2'd1 : 2'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
